// File: rtl/a2bus_write_capture.sv
// Captures qualifying A2 bus cycles into a first-word-fall-through FIFO, with a sticky
// overflow flag and a saturating count of events dropped while the FIFO was full.
module a2bus_write_capture #(
  parameter int unsigned DEPTH         = 8,
  parameter logic [15:0] ADDR_BASE     = 16'hC080,
  parameter logic [15:0] ADDR_MASK     = 16'hFFF0,
  parameter bit          CAPTURE_READS = 1'b0,
  localparam int unsigned AW           = $clog2(DEPTH),
  localparam int unsigned CW           = AW + 1
) (
  input  logic          clk_logic,
  input  logic          device_reset,
  input  logic          enable_i,
  input  logic [15:0]   addr_i,
  input  logic [7:0]    data_i,
  input  logic          rw_n_i,
  input  logic          data_in_strobe_i,
  output logic          ev_valid_o,
  input  logic          ev_ready_i,
  output logic [15:0]   ev_addr_o,
  output logic [7:0]    ev_data_o,
  output logic          ev_rw_n_o,
  output logic [CW-1:0] count_o,
  output logic          overflow_o,
  output logic [7:0]    drop_count_o,
  input  logic          clear_overflow_i
);

  logic [24:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [7:0]    r_drop_count;

  logic w_match;
  logic w_qual;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_match = (addr_i & ADDR_MASK) == ADDR_BASE;
  assign w_qual  = data_in_strobe_i && enable_i && w_match && (!rw_n_i || CAPTURE_READS);
  assign w_full  = r_count == CW'(DEPTH);
  assign w_pop   = (r_count != '0) && ev_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
  assign w_push  = w_qual && (!w_full || w_pop);
  assign w_drop  = w_qual && w_full && !w_pop;

  // Storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk_logic) begin
    if (w_push) begin
      r_mem[r_wptr] <= {addr_i, data_i, rw_n_i};
    end
  end

  always_ff @(posedge clk_logic or posedge device_reset) begin
    if (device_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_logic or posedge device_reset) begin
    if (device_reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (clear_overflow_i) begin
      // A drop coinciding with the clear is the first event of the new window.
      r_overflow   <= w_drop;
      r_drop_count <= w_drop ? 8'd1 : 8'd0;
    end else if (w_drop) begin
      r_overflow   <= 1'b1;
      if (r_drop_count != 8'hFF) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  assign ev_valid_o   = r_count != '0;
  assign ev_addr_o    = r_mem[r_rptr][24:9];
  assign ev_data_o    = r_mem[r_rptr][8:1];
  assign ev_rw_n_o    = r_mem[r_rptr][0];
  assign count_o      = r_count;
  assign overflow_o   = r_overflow;
  assign drop_count_o = r_drop_count;

endmodule

// File: tb/tb_a2bus_write_capture.sv
// Directed and randomized bench for a2bus_write_capture against a queue-based model.
module tb_a2bus_write_capture;

  localparam int unsigned DEPTH = 8;
  localparam logic [15:0] BASE  = 16'hC080;
  localparam logic [15:0] MASK  = 16'hFFF0;

  logic        clk_logic = 1'b0;
  logic        device_reset = 1'b1;
  logic        enable_i = 1'b0;
  logic [15:0] addr_i = '0;
  logic [7:0]  data_i = '0;
  logic        rw_n_i = 1'b1;
  logic        data_in_strobe_i = 1'b0;
  logic        ev_valid_o;
  logic        ev_ready_i = 1'b0;
  logic [15:0] ev_addr_o;
  logic [7:0]  ev_data_o;
  logic        ev_rw_n_o;
  logic [3:0]  count_o;
  logic        overflow_o;
  logic [7:0]  drop_count_o;
  logic        clear_overflow_i = 1'b0;

  a2bus_write_capture #(
    .DEPTH(DEPTH), .ADDR_BASE(BASE), .ADDR_MASK(MASK), .CAPTURE_READS(1'b0)
  ) dut (
    .clk_logic        (clk_logic),
    .device_reset     (device_reset),
    .enable_i         (enable_i),
    .addr_i           (addr_i),
    .data_i           (data_i),
    .rw_n_i           (rw_n_i),
    .data_in_strobe_i (data_in_strobe_i),
    .ev_valid_o       (ev_valid_o),
    .ev_ready_i       (ev_ready_i),
    .ev_addr_o        (ev_addr_o),
    .ev_data_o        (ev_data_o),
    .ev_rw_n_o        (ev_rw_n_o),
    .count_o          (count_o),
    .overflow_o       (overflow_o),
    .drop_count_o     (drop_count_o),
    .clear_overflow_i (clear_overflow_i)
  );

  always #5 clk_logic = ~clk_logic;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: captured events in arrival order plus the overflow bookkeeping.
  logic [24:0] m_q[$];
  bit          m_ov = 1'b0;
  int          m_dc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("count", 32'(count_o), 32'(m_q.size()));
    chk("valid", 32'(ev_valid_o), 32'(m_q.size() != 0));
    chk("overflow", 32'(overflow_o), 32'(m_ov));
    chk("drop_count", 32'(drop_count_o), 32'(m_dc));
    if (m_q.size() != 0) begin
      chk("head_addr", 32'(ev_addr_o), 32'(m_q[0][24:9]));
      chk("head_data", 32'(ev_data_o), 32'(m_q[0][8:1]));
      chk("head_rw_n", 32'(ev_rw_n_o), 32'(m_q[0][0]));
    end
  endtask

  task automatic model_step();
    bit qual, pop, full, drop;
    qual = data_in_strobe_i && enable_i && ((addr_i & MASK) == BASE) && !rw_n_i;
    pop  = (m_q.size() != 0) && ev_ready_i;
    full = m_q.size() == DEPTH;
    drop = qual && full && !pop;
    if (pop) void'(m_q.pop_front());
    if (qual && !drop) m_q.push_back({addr_i, data_i, rw_n_i});
    if (clear_overflow_i) begin
      m_ov = drop;
      m_dc = drop ? 1 : 0;
    end else if (drop) begin
      m_ov = 1'b1;
      m_dc = (m_dc >= 255) ? 255 : m_dc + 1;
    end
  endtask

  // One clock: inputs already applied; check state at negedge, then advance.
  task automatic tick();
    @(negedge clk_logic);
    check_outputs();
    model_step();
    @(posedge clk_logic);
    #1;
  endtask

  task automatic drive(input bit stb, input logic [15:0] a, input logic [7:0] d,
                       input bit rwn, input bit rdy);
    data_in_strobe_i = stb;
    addr_i = a;
    data_i = d;
    rw_n_i = rwn;
    ev_ready_i = rdy;
    tick();
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, 16'h0000, 8'h00, 1'b1, rdy);
  endtask

  initial begin
    #2;
    chk("reset_count", 32'(count_o), 32'd0);
    chk("reset_valid", 32'(ev_valid_o), 32'd0);
    chk("reset_overflow", 32'(overflow_o), 32'd0);
    chk("reset_drop_count", 32'(drop_count_o), 32'd0);
    @(posedge clk_logic);
    #1 device_reset = 1'b0;
    enable_i = 1'b1;

    // Single write with consumer ready: visible one cycle, then drained.
    drive(1'b1, 16'hC08B, 8'h5A, 1'b0, 1'b1);
    chk("single_valid", 32'(ev_valid_o), 32'd1);
    chk("single_addr", 32'(ev_addr_o), 32'hC08B);
    idle(1'b1);
    idle(1'b1);

    // Non-matching addresses and a read are ignored.
    drive(1'b1, 16'hC07F, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 16'hC090, 8'h22, 1'b0, 1'b0);
    drive(1'b1, 16'hC080, 8'h33, 1'b1, 1'b0);
    idle(1'b0);
    chk("nomatch_count", 32'(count_o), 32'd0);

    // Nine writes into a depth-8 FIFO: last one dropped.
    for (int i = 0; i < 9; i++) drive(1'b1, 16'hC080 + 16'(i), 8'(8'hA0 + i), 1'b0, 1'b0);
    idle(1'b0);
    chk("fill_overflow", 32'(overflow_o), 32'd1);
    chk("fill_drop_count", 32'(drop_count_o), 32'd1);

    // Full with simultaneous strobe and pop: no drop, new entry goes to the tail.
    drive(1'b1, 16'hC08F, 8'hEE, 1'b0, 1'b1);
    chk("full_pop_count", 32'(count_o), 32'd8);
    chk("full_pop_drop_count", 32'(drop_count_o), 32'd1);
    for (int i = 0; i < 8; i++) idle(1'b1);
    idle(1'b1);
    drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    clear_overflow_i = 1'b1;
    idle(1'b0);
    clear_overflow_i = 1'b0;

    // Saturation of the drop counter, clear, then clear coinciding with a drop.
    for (int i = 0; i < 8; i++) drive(1'b1, 16'hC081, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) drive(1'b1, 16'hC082, 8'(i), 1'b0, 1'b0);
    idle(1'b0);
    chk("sat_drop_count", 32'(drop_count_o), 32'd255);
    clear_overflow_i = 1'b1;
    idle(1'b0);
    chk("clear_overflow", 32'(overflow_o), 32'd0);
    chk("clear_drop_count", 32'(drop_count_o), 32'd0);
    drive(1'b1, 16'hC083, 8'h77, 1'b0, 1'b0);
    clear_overflow_i = 1'b0;
    idle(1'b0);
    chk("clear_drop_overflow", 32'(overflow_o), 32'd1);
    chk("clear_drop_count1", 32'(drop_count_o), 32'd1);

    // Enable low blocks pushes but stored entries still drain.
    enable_i = 1'b0;
    drive(1'b1, 16'hC084, 8'h44, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) idle(1'b1);
    enable_i = 1'b1;

    // Reset with five entries while a handshake is in progress.
    for (int i = 0; i < 5; i++) drive(1'b1, 16'hC085, 8'(8'h50 + i), 1'b0, 1'b0);
    data_in_strobe_i = 1'b1;
    addr_i = 16'hC086;
    ev_ready_i = 1'b1;
    #2 device_reset = 1'b1;
    #1;
    chk("async_reset_count", 32'(count_o), 32'd0);
    chk("async_reset_valid", 32'(ev_valid_o), 32'd0);
    chk("async_reset_overflow", 32'(overflow_o), 32'd0);
    m_q.delete();
    m_ov = 1'b0;
    m_dc = 0;
    @(posedge clk_logic);
    @(posedge clk_logic);
    #1 device_reset = 1'b0;
    drive(1'b1, 16'hC08C, 8'hC3, 1'b0, 1'b0);
    chk("post_reset_valid", 32'(ev_valid_o), 32'd1);
    chk("post_reset_data", 32'(ev_data_o), 32'hC3);
    idle(1'b1);
    idle(1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      enable_i = ($urandom_range(0, 7) != 0);
      clear_overflow_i = ($urandom_range(0, 31) == 0);
      drive(($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0) ? (16'hC080 | 16'($urandom_range(0, 15)))
                                        : 16'($urandom),
            8'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
    end
    clear_overflow_i = 1'b0;
    idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
